// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-side bus bundle: program memory port, decode handshake and execute redirect.
// The master modport belongs to the fetch controller.
interface instr_fetch_ctrl_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_ins;
    logic [31:0] ins_out;
    logic [31:0] pc_out;
    logic        ins_valid;
    logic        ins_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output imem_addr,
        output ins_out,
        output pc_out,
        output ins_valid,
        input  imem_ins,
        input  ins_ready,
        input  redirect_valid,
        input  redirect_pc
    );

    modport slave (
        input  imem_addr,
        input  ins_out,
        input  pc_out,
        input  ins_valid,
        output imem_ins,
        output ins_ready,
        output redirect_valid,
        output redirect_pc
    );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, fetches from a combinational ROM into a
// one-entry valid/ready output stage. Define FETCH_PERF_EN to add fetch/flush counters.
module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_BYTES = 48
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    instr_fetch_ctrl_if.master bus,
    output logic               halted,
    output logic               fault,
    output logic [31:0]        fault_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        fetch_count,
    output logic [15:0]        flush_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ins_q, ins_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;
    logic [31:0] fault_pc_q, fault_pc_d;

    logic pc_legal;
    logic redirect_aligned;
    logic load;

    assign pc_legal         = (pc_q[1:0] == 2'b00) && (pc_q <= LAST_PC);
    assign redirect_aligned = (bus.redirect_pc[1:0] == 2'b00);
    assign load             = (state_q == ST_RUN) && pc_legal &&
                              (!valid_q || bus.ins_ready) && !bus.redirect_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            ins_q      <= '0;
            pc_out_q   <= '0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ins_q      <= ins_d;
            pc_out_q   <= pc_out_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ins_d      = ins_q;
        pc_out_d   = pc_out_q;
        valid_d    = valid_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;

        // A handshake retires the held entry; a load or flush below may override it.
        if (valid_q && bus.ins_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.redirect_valid) begin
                    if (redirect_aligned) begin
                        pc_d = bus.redirect_pc;
                    end
                end else if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN, ST_HALT: begin
                if (bus.redirect_valid) begin
                    valid_d = 1'b0;
                    if (redirect_aligned) begin
                        pc_d    = bus.redirect_pc;
                        state_d = ST_RUN;
                    end else begin
                        fault_d    = 1'b1;
                        fault_pc_d = bus.redirect_pc;
                        state_d    = ST_FAULT;
                    end
                end else if (state_q == ST_RUN) begin
                    if (!pc_legal) begin
                        state_d = ST_HALT;
                    end else if (load) begin
                        ins_d    = bus.imem_ins;
                        pc_out_d = pc_q;
                        valid_d  = 1'b1;
                        pc_d     = pc_q + 32'd4;
                    end
                end
            end
            ST_FAULT: begin
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.imem_addr = pc_q;
    assign bus.ins_out   = ins_q;
    assign bus.pc_out    = pc_out_q;
    assign bus.ins_valid = valid_q;
    assign halted        = (state_q == ST_HALT);
    assign fault         = fault_q;
    assign fault_pc      = fault_pc_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [15:0] flush_count_q, flush_count_d;
    logic        flush_drop;

    // Only a redirect that throws away an instruction decode never took counts as a flush.
    assign flush_drop = ((state_q == ST_RUN) || (state_q == ST_HALT)) &&
                        bus.redirect_valid && redirect_aligned &&
                        valid_q && !bus.ins_ready;

    always_comb begin
        fetch_count_d = fetch_count_q;
        flush_count_d = flush_count_q;
        if (load && (fetch_count_q != '1)) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
        if (flush_drop && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Testbench for instr_fetch_ctrl: directed scenarios plus randomized traffic checked
// against a behavioural model of the fetch rules (FETCH_PERF_EN adds counter checks).
module tb_instr_fetch_ctrl;

    localparam int          MEM_BYTES = 48;
    localparam int          WORDS     = MEM_BYTES / 4;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        start;
    logic        halted;
    logic        fault;
    logic [31:0] fault_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [15:0] flush_count;
`endif

    instr_fetch_ctrl_if bus ();

    instr_fetch_ctrl #(
        .RESET_PC  (RESET_PC),
        .MEM_BYTES (MEM_BYTES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bus      (bus.master),
        .halted   (halted),
        .fault    (fault),
        .fault_pc (fault_pc)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count (fetch_count),
        .flush_count (flush_count)
`endif
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] rom [WORDS];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational program memory; out-of-range reads return a recognisable junk pattern.
    always_comb begin
        if (bus.imem_addr[1:0] == 2'b00 && bus.imem_addr < 32'(MEM_BYTES))
            bus.imem_ins = rom[int'(bus.imem_addr >> 2)];
        else
            bus.imem_ins = 32'hBAD0_0000 ^ bus.imem_addr;
    end

    // Behavioural model: the fetcher is idle, running, halted or faulted, holds at most one
    // instruction for decode, and fetches whenever running, in range and the slot frees.
    logic [31:0] m_pc, m_ins, m_pc_out, m_fault_pc;
    bit          m_valid, m_run, m_halt, m_fault;
    bit          m_take, m_room, m_in_range;
    int unsigned m_fetches, m_flushes;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc = RESET_PC; m_ins = 0; m_pc_out = 0; m_fault_pc = 0;
            m_valid = 0; m_run = 0; m_halt = 0; m_fault = 0;
            m_fetches = 0; m_flushes = 0;
        end else begin
            m_take     = m_valid && bus.ins_ready;
            m_room     = !m_valid || bus.ins_ready;
            m_in_range = (m_pc % 4 == 0) && (m_pc <= 32'(MEM_BYTES - 4));
            if (m_fault) begin
                if (m_take) m_valid = 0;
            end else if (bus.redirect_valid) begin
                if (bus.redirect_pc % 4 == 0) begin
                    if (m_run || m_halt) begin
                        if (m_valid && !bus.ins_ready) m_flushes++;
                        m_valid = 0; m_run = 1; m_halt = 0;
                    end else if (m_take) begin
                        m_valid = 0;
                    end
                    m_pc = bus.redirect_pc;
                end else if (m_run || m_halt) begin
                    m_fault = 1; m_fault_pc = bus.redirect_pc;
                    m_valid = 0; m_run = 0; m_halt = 0;
                end else if (m_take) begin
                    m_valid = 0;
                end
            end else if (m_run && !m_in_range) begin
                m_run = 0; m_halt = 1;
                if (m_take) m_valid = 0;
            end else if (m_run && m_room) begin
                m_ins = rom[m_pc / 4]; m_pc_out = m_pc; m_valid = 1;
                m_pc = m_pc + 4; m_fetches++;
            end else begin
                if (m_take) m_valid = 0;
                if (!m_run && !m_halt && start) m_run = 1;
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1; start = 1'b0;
        bus.ins_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
        repeat (2) @(negedge clk);
        total++;
        if (bus.ins_valid !== 1'b0 || bus.ins_out !== 32'h0 || bus.pc_out !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_stage: got valid=%0b ins=%h pc=%h want 0/0/0", bus.ins_valid, bus.ins_out, bus.pc_out);
        end
        total++;
        if (halted !== 1'b0 || fault !== 1'b0 || fault_pc !== 32'h0 || bus.imem_addr !== RESET_PC) begin
            bad++;
            $display("[TB] FAIL reset_status: got halted=%0b fault=%0b fault_pc=%h addr=%h want 0/0/0/%h", halted, fault, fault_pc, bus.imem_addr, RESET_PC);
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (bus.ins_valid !== 1'b0 || bus.imem_addr !== RESET_PC) begin
            bad++;
            $display("[TB] FAIL idle_no_fetch: got valid=%0b addr=%h want 0/%h", bus.ins_valid, bus.imem_addr, RESET_PC);
        end
    endtask

    task automatic test_stream();
        start = 1'b1; bus.ins_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (bus.ins_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL start_latency: got valid=%0b want 0", bus.ins_valid);
        end
        for (int k = 0; k < WORDS; k++) begin
            @(negedge clk);
            total++;
            if (bus.ins_valid !== 1'b1 || bus.pc_out !== 32'(4 * k) || bus.ins_out !== rom[k]) begin
                bad++;
                $display("[TB] FAIL stream_%0d: got valid=%0b pc=%h ins=%h want 1/%h/%h", k, bus.ins_valid, bus.pc_out, bus.ins_out, 32'(4 * k), rom[k]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (halted !== 1'b1 || bus.ins_valid !== 1'b0 || bus.imem_addr !== 32'(MEM_BYTES)) begin
                bad++;
                $display("[TB] FAIL end_halt_%0d: got halted=%0b valid=%0b addr=%h want 1/0/%h", i, halted, bus.ins_valid, bus.imem_addr, 32'(MEM_BYTES));
            end
        end
    endtask

    task automatic test_stall();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0; bus.ins_ready = 1'b1;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (bus.ins_valid !== 1'b1 || bus.pc_out !== 32'(4 * k)) begin
                bad++;
                $display("[TB] FAIL stall_lead_%0d: got valid=%0b pc=%h want 1/%h", k, bus.ins_valid, bus.pc_out, 32'(4 * k));
            end
        end
        bus.ins_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (bus.ins_valid !== 1'b1 || bus.pc_out !== 32'h8 || bus.ins_out !== rom[2] || bus.imem_addr !== 32'hC) begin
                bad++;
                $display("[TB] FAIL stall_hold_%0d: got valid=%0b pc=%h ins=%h addr=%h want 1/8/%h/c", i, bus.ins_valid, bus.pc_out, bus.ins_out, bus.imem_addr, rom[2]);
            end
        end
        bus.ins_ready = 1'b1;
        for (int k = 3; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (bus.ins_valid !== 1'b1 || bus.pc_out !== 32'(4 * k) || bus.ins_out !== rom[k]) begin
                bad++;
                $display("[TB] FAIL stall_release_%0d: got valid=%0b pc=%h ins=%h want 1/%h/%h", k, bus.ins_valid, bus.pc_out, bus.ins_out, 32'(4 * k), rom[k]);
            end
        end
    endtask

    task automatic test_redirect_flush();
        int n;
        n = 0;
        while (!(bus.ins_valid === 1'b1 && bus.pc_out === 32'h20) && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 20) begin
            bad++;
            $display("[TB] FAIL flush_reach_20: got pc=%h want 20 within 20 cycles", bus.pc_out);
        end
        bus.ins_ready = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h10;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        total++;
        if (bus.ins_valid !== 1'b0 || bus.imem_addr !== 32'h10) begin
            bad++;
            $display("[TB] FAIL flush_drop: got valid=%0b addr=%h want 0/10", bus.ins_valid, bus.imem_addr);
        end
        @(negedge clk);
        total++;
        if (bus.ins_valid !== 1'b1 || bus.pc_out !== 32'h10 || bus.ins_out !== rom[4]) begin
            bad++;
            $display("[TB] FAIL flush_target: got valid=%0b pc=%h ins=%h want 1/10/%h", bus.ins_valid, bus.pc_out, bus.ins_out, rom[4]);
        end
`ifdef FETCH_PERF_EN
        total++;
        if (flush_count !== 16'd1) begin
            bad++;
            $display("[TB] FAIL flush_count: got %0d want 1", flush_count);
        end
`endif
        bus.ins_ready = 1'b1;
    endtask

    task automatic test_halt_redirect();
        int n;
        n = 0;
        while (halted !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (halted !== 1'b1) begin
            bad++;
            $display("[TB] FAIL halt_reach: got halted=%0b want 1 within 30 cycles", halted);
        end
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h1C;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        total++;
        if (halted !== 1'b0 || bus.ins_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL halt_exit: got halted=%0b valid=%0b want 0/0", halted, bus.ins_valid);
        end
        for (int k = 7; k < 9; k++) begin
            @(negedge clk);
            total++;
            if (bus.ins_valid !== 1'b1 || bus.pc_out !== 32'(4 * k) || bus.ins_out !== rom[k]) begin
                bad++;
                $display("[TB] FAIL halt_resume_%0d: got valid=%0b pc=%h ins=%h want 1/%h/%h", k, bus.ins_valid, bus.pc_out, bus.ins_out, 32'(4 * k), rom[k]);
            end
        end
    endtask

    task automatic test_fault();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0E;
        @(negedge clk);
        total++;
        if (fault !== 1'b1 || fault_pc !== 32'h0E || bus.ins_valid !== 1'b0 || bus.imem_addr !== 32'h24) begin
            bad++;
            $display("[TB] FAIL fault_enter: got fault=%0b fault_pc=%h valid=%0b addr=%h want 1/e/0/24", fault, fault_pc, bus.ins_valid, bus.imem_addr);
        end
        bus.redirect_pc = 32'h0; start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (fault !== 1'b1 || fault_pc !== 32'h0E || bus.ins_valid !== 1'b0 || halted !== 1'b0 || bus.imem_addr !== 32'h24) begin
                bad++;
                $display("[TB] FAIL fault_sticky_%0d: got fault=%0b fault_pc=%h valid=%0b halted=%0b addr=%h want 1/e/0/0/24", i, fault, fault_pc, bus.ins_valid, halted, bus.imem_addr);
            end
        end
        bus.redirect_valid = 1'b0; start = 1'b0;
    endtask

    task automatic test_async_reset();
        #3 reset = 1'b1;
        #1;
        total++;
        if (fault !== 1'b0 || fault_pc !== 32'h0 || halted !== 1'b0 || bus.imem_addr !== RESET_PC) begin
            bad++;
            $display("[TB] FAIL async_clear_fault: got fault=%0b fault_pc=%h halted=%0b addr=%h want 0/0/0/%h", fault, fault_pc, halted, bus.imem_addr, RESET_PC);
        end
        @(negedge clk);
        reset = 1'b0; start = 1'b1; bus.ins_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        bus.ins_ready = 1'b0;
        @(negedge clk);
        total++;
        if (bus.ins_valid !== 1'b1 || bus.pc_out !== 32'h4) begin
            bad++;
            $display("[TB] FAIL async_pre_hold: got valid=%0b pc=%h want 1/4", bus.ins_valid, bus.pc_out);
        end
        #3 reset = 1'b1;
        #1;
        total++;
        if (bus.ins_valid !== 1'b0 || bus.ins_out !== 32'h0 || bus.pc_out !== 32'h0 || bus.imem_addr !== RESET_PC || halted !== 1'b0 || fault !== 1'b0) begin
            bad++;
            $display("[TB] FAIL async_midrun: got valid=%0b ins=%h pc=%h addr=%h halted=%0b fault=%0b want 0/0/0/%h/0/0", bus.ins_valid, bus.ins_out, bus.pc_out, bus.imem_addr, halted, fault, RESET_PC);
        end
        @(negedge clk);
        reset = 1'b0; start = 1'b1; bus.ins_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        total++;
        if (bus.ins_valid !== 1'b1 || bus.pc_out !== RESET_PC || bus.ins_out !== rom[0]) begin
            bad++;
            $display("[TB] FAIL async_refetch: got valid=%0b pc=%h ins=%h want 1/%h/%h", bus.ins_valid, bus.pc_out, bus.ins_out, RESET_PC, rom[0]);
        end
    endtask

    task automatic test_random();
        int kind;
        for (int seg = 0; seg < 4; seg++) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            for (int i = 0; i < 150; i++) begin
                @(negedge clk);
                total++;
                if (bus.ins_valid !== m_valid || bus.pc_out !== m_pc_out || bus.ins_out !== m_ins) begin
                    bad++;
                    $display("[TB] FAIL rand_stage s%0d c%0d: got valid=%0b pc=%h ins=%h want %0b/%h/%h", seg, i, bus.ins_valid, bus.pc_out, bus.ins_out, m_valid, m_pc_out, m_ins);
                end
                total++;
                if (bus.imem_addr !== m_pc || halted !== m_halt || fault !== m_fault || fault_pc !== m_fault_pc) begin
                    bad++;
                    $display("[TB] FAIL rand_status s%0d c%0d: got addr=%h halted=%0b fault=%0b fault_pc=%h want %h/%0b/%0b/%h", seg, i, bus.imem_addr, halted, fault, fault_pc, m_pc, m_halt, m_fault, m_fault_pc);
                end
                start              = ($urandom_range(0, 9) == 0);
                bus.ins_ready      = ($urandom_range(0, 9) < 7);
                bus.redirect_valid = ($urandom_range(0, 99) < 8);
                kind               = int'($urandom_range(0, 9));
                if (kind <= 5)
                    bus.redirect_pc = 32'($urandom_range(0, WORDS - 1) * 4);
                else if (kind == 6)
                    bus.redirect_pc = 32'(MEM_BYTES - 4);
                else if (kind == 7)
                    bus.redirect_pc = ($urandom_range(0, 1) == 0) ? 32'(MEM_BYTES) : 32'hFFFF_FFFC;
                else if ($urandom_range(0, 3) == 0)
                    bus.redirect_pc = 32'($urandom_range(0, WORDS - 1) * 4 + $urandom_range(1, 3));
                else
                    bus.redirect_pc = 32'($urandom_range(0, WORDS - 1) * 4);
                if (!bus.redirect_valid)
                    bus.redirect_pc = $urandom;
            end
`ifdef FETCH_PERF_EN
            @(negedge clk);
            total++;
            if (fetch_count !== 32'(m_fetches) || flush_count !== 16'(m_flushes)) begin
                bad++;
                $display("[TB] FAIL rand_counters s%0d: got fetch=%0d flush=%0d want %0d/%0d", seg, fetch_count, flush_count, m_fetches, m_flushes);
            end
`endif
        end
        bus.redirect_valid = 1'b0; start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < WORDS; i++) rom[i] = $urandom;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_flush();
        test_halt_redirect();
        test_fault();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
- Sequences the single-cycle combinational program memory (byte-addressed, 32-bit little-endian word read) for the RV32 core.
- Owns the PC, drives the memory address, and registers each fetched instruction into a one-entry output stage with a valid/ready handshake to decode.
- Accepts redirects from execute (branch/jump), stops at the end of the program image, and faults on misaligned targets.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- MEM_BYTES, 48, program memory size in bytes. Legal fetch iff pc[1:0]==0 and pc <= MEM_BYTES-4.

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin fetching from current pc (IDLE only)
- imem_addr  out  32  byte address to program memory; combinationally equal to pc
- imem_ins  in  32  instruction word returned combinationally for imem_addr
- ins_out  out  32  registered instruction to decode
- pc_out  out  32  PC of ins_out
- ins_valid  out  1  ins_out/pc_out hold a valid instruction
- ins_ready  in  1  decode accepts ins_out this cycle
- redirect_valid  in  1  load new pc, flush output stage
- redirect_pc  in  32  redirect target
- halted  out  1  high in HALT state
- fault  out  1  sticky misaligned-redirect fault
- fault_pc  out  32  offending redirect_pc

Behaviour:
- Reset (asynchronous, any time, including mid-transfer): state=IDLE, pc=RESET_PC, ins_out=0, pc_out=0, ins_valid=0, halted=0, fault=0, fault_pc=0.
- States: IDLE, RUN, HALT, FAULT. Encoded as a registered state machine.
- load = (state==RUN) && legal(pc) && (!ins_valid || ins_ready) && !redirect_valid.
- On load at a clock edge: ins_out<=imem_ins, pc_out<=pc, ins_valid<=1, pc<=pc+4.
- When ins_valid && ins_ready && !load: ins_valid<=0.
- When ins_valid && !ins_ready: ins_out/pc_out/ins_valid hold. No loss and no duplication.
- IDLE: no loads. start=1 -> RUN. A redirect in IDLE updates pc (aligned) and stays in IDLE.
- RUN: if !legal(pc) and no redirect -> HALT. No load that cycle; any already-valid instruction remains until accepted.
- HALT: halted=1, no loads. redirect_valid with aligned target -> RUN with pc<=redirect_pc. start is ignored.
- Redirect priority: redirect_valid beats load, start, and range stop in every state except FAULT.
- Aligned redirect: pc<=redirect_pc, ins_valid<=0 (flush), state<=RUN, except from IDLE.
- A handshake (ins_valid && ins_ready) in the redirect cycle counts as consumed by decode.
- Misaligned redirect (redirect_pc[1:0]!=0) in RUN/HALT: fault<=1, fault_pc<=redirect_pc, ins_valid<=0, state<=FAULT, pc unchanged.
- A misaligned redirect in IDLE is ignored.
- FAULT: no loads, redirect ignored. Exit only via reset.
- Latency:
  - After start at edge N, first ins_valid=1 after edge N+1 (pc=RESET_PC). Thereafter, with ins_ready=1, one instruction per cycle.
  - After redirect at edge N, the target instruction is valid after edge N+1.
- Range check uses unsigned 32-bit compare. pc+4 wraps modulo 2^32, but the range check stops fetching before any wrap.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: adds output ports fetch_count[31:0] (increments on each load) and flush_count[15:0] (increments on each aligned redirect that drops a valid, unaccepted instruction). Both saturate at all-ones and reset to 0.
- Undefined: ports and counters are absent. All other behaviour is identical.

Test Plan:
- reset, start pulse, ins_ready=1, ROM image of 12 words -> ins_valid high from 2nd edge after start; pc_out sequence 0,4,…,44. At pc=48, halted=1 and no further valids.
- ins_ready=0 for 3 cycles while valid at pc_out=8 -> ins_out/pc_out stable, pc stays 12. On release, next pc_out=12 with no skip or duplicate.
- redirect_valid with redirect_pc=0x10 while pc_out=0x20 valid, ins_ready=0 -> ins_valid=0 next cycle, then pc_out=0x10 valid one cycle later.
- In HALT, redirect_pc=0x1C -> halted=0, fetch resumes with pc_out=0x1C, 0x20.
- redirect_pc=0x0E -> fault=1, fault_pc=0x0E, ins_valid=0. Subsequent redirect_pc=0x0 and start are ignored until reset.
- Assert reset while ins_valid=1 and ins_ready=0 mid-run -> all outputs take reset values immediately (without waiting for a clock edge). A start after reset refetches from RESET_PC.
